forward_ctrl: RTL and testbench
===============================

// Module: forward_ctrl
// PURPOSE
//  Forwarding/hazard control for the 4-stage EXE path: tracks destination registers through
//  ID/EX, EX/MEM and MEM/WB in its own shadow pipeline and drives the 2-bit select inputs of
//  the ALU port-A and port-B forwarding muxes.
//  Also detects load-use hazards and requests a one-cycle stall with a bubble into EXE.
// PARAMETERS
//  AW     5   register-address width; register 0 is hard-wired zero, never forwarded
// PORTS
//  clk           in   1    pipeline clock
//  rst           in   1    synchronous reset, active-high
//  id_rs1        in   AW   source reg 1 of instruction in ID
//  id_rs2        in   AW   source reg 2 of instruction in ID
//  id_rd         in   AW   destination reg of instruction in ID
//  id_reg_write  in   1    ID instruction writes register file
//  id_mem_read   in   1    ID instruction is a load
//  id_use_imm    in   1    ID instruction feeds immediate to ALU port B
//  flush         in   1    squash ID instruction (branch taken)
//  fwd_a_sel     out  2    port-A mux select: 0 regfile, 1 EX/MEM, 2 MEM/WB
//  fwd_b_sel     out  2    port-B mux select: same encoding; 3 never driven
//  stall         out  1    hold PC and IF/ID this cycle
//  stall_count   out  16   saturating count of load-use stall cycles
// BEHAVIOUR
//  - Shadow regs: ex_{rs1,rs2,rd,wr,mrd,imm}, mem_{rd,wr,mrd}, wb_{rd,wr}; advance every clk.
//  - rst (sync): all shadow wr/mrd/imm bits 0, all rd/rs fields 0, stall_count 0;
//    hence fwd_a_sel=0, fwd_b_sel=0, stall=0 in the cycle after rst.
//  - Shift: mem<=ex, wb<=mem every cycle (never stalled; EXE onward always drains).
//  - ID/EX load: if stall or flush, ex_* <= bubble (wr=0, mrd=0, imm=0, rs/rd=0);
//    else ex_* <= id_*.
//  - fwd_a_sel (combinational from shadow regs, valid for instruction now in EXE):
//    1 if mem_wr && mem_rd!=0 && mem_rd==ex_rs1;
//    else 2 if wb_wr && wb_rd!=0 && wb_rd==ex_rs1; else 0. EX/MEM has priority.
//  - fwd_b_sel: same rule on ex_rs2, but forced 0 when ex_imm=1 (immediate path).
//  - Forward from EX/MEM when mem_mrd=1 cannot occur: stall guarantees the load has reached
//    MEM/WB before its consumer is in EXE; no special case needed, assertion in bench.
//  - stall (combinational): ex_mrd && ex_wr && ex_rd!=0 &&
//    (ex_rd==id_rs1 || (!id_use_imm && ex_rd==id_rs2)). Exactly one cycle per load-use:
//    the bubble clears ex_mrd, so stall drops next cycle.
//  - flush and stall together: bubble inserted, stall still asserted (PC hold is harmless).
//  - stall_count increments on each cycle stall=1, saturates at 16'hFFFF, no wrap.
//  - Latency: selects valid in the same cycle the consumer occupies EXE; zero added cycles
//    except the single load-use stall.
// TESTING
//  1) rst, then ADD r3<-r1,r2 ; SUB r4<-r3,r5 back-to-back -> SUB in EXE: fwd_a_sel=1, b=0.
//  2) ADD r3 ; NOP ; OR r6<-r7,r3 -> OR in EXE: fwd_b_sel=2, fwd_a_sel=0, stall never 1.
//  3) LW r2 ; ADD r8<-r2,r2 -> stall=1 one cycle, bubble in EXE, then ADD in EXE
//     with fwd_a_sel=2 and fwd_b_sel=2; stall_count=1.
//  4) ADD r0<-r1,r1 ; SUB r9<-r0,r0 -> both selects 0 (r0 never forwarded); LW r0 ; use r0
//     -> no stall.
//  5) ADD r5 ; ADD r5 ; ADDI r6<-r5,imm -> fwd_a_sel=1 (newest wins), fwd_b_sel=0 (imm).
//  6) LW r4 with consumer in ID, assert rst mid-stall -> next cycle stall=0, selects 0,
//     stall_count=0; LW r4 ; flush on consumer -> bubble, no forward to squashed op.

Source files
------------

// File: rtl/forward_ctrl.sv
// forward_ctrl
//   Forwarding and load-use hazard control for the 4-stage EXE path.
//   A shadow pipeline (ID/EX -> EX/MEM -> MEM/WB) tracks register usage.
//   The ALU port-A and port-B forwarding selects are derived from that
//   shadow state. A one-cycle stall is requested when a load is followed
//   directly by a consumer of its result.
//
// Ports
//   clk, rst                 pipeline clock, synchronous active-high reset
//   id_rs1, id_rs2, id_rd    register fields of the instruction in ID
//   id_reg_write             ID instruction writes the register file
//   id_mem_read              ID instruction is a load
//   id_use_imm               ID instruction feeds an immediate to ALU port B
//   flush                    squash the ID instruction (branch taken)
//   fwd_a_sel, fwd_b_sel     0 regfile, 1 EX/MEM, 2 MEM/WB
//   stall                    hold PC and IF/ID this cycle
//   stall_count              saturating count of load-use stall cycles
module forward_ctrl #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_use_imm,
    input  logic          flush,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel,
    output logic          stall,
    output logic [15:0]   stall_count
);

    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          ex_wr, ex_mrd, ex_imm;
    logic [AW-1:0] mem_rd;
    logic          mem_wr, mem_mrd;
    logic [AW-1:0] wb_rd;
    logic          wb_wr;

    // Shadow pipeline. EXE onward always drains; only ID/EX takes a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            ex_rd   <= '0;
            ex_wr   <= 1'b0;
            ex_mrd  <= 1'b0;
            ex_imm  <= 1'b0;
            mem_rd  <= '0;
            mem_wr  <= 1'b0;
            mem_mrd <= 1'b0;
            wb_rd   <= '0;
            wb_wr   <= 1'b0;
        end else begin
            mem_rd  <= ex_rd;
            mem_wr  <= ex_wr;
            mem_mrd <= ex_mrd;
            wb_rd   <= mem_rd;
            wb_wr   <= mem_wr;
            if (stall || flush) begin
                ex_rs1 <= '0;
                ex_rs2 <= '0;
                ex_rd  <= '0;
                ex_wr  <= 1'b0;
                ex_mrd <= 1'b0;
                ex_imm <= 1'b0;
            end else begin
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
                ex_rd  <= id_rd;
                ex_wr  <= id_reg_write;
                ex_mrd <= id_mem_read;
                ex_imm <= id_use_imm;
            end
        end
    end

    logic mem_fwd_ok, wb_fwd_ok;

    // Register 0 is hard-wired zero and is never a forwarding source.
    always_comb begin
        mem_fwd_ok = mem_wr && (mem_rd != '0);
        wb_fwd_ok  = wb_wr && (wb_rd != '0);

        fwd_a_sel = 2'd0;
        if (mem_fwd_ok && (mem_rd == ex_rs1))
            fwd_a_sel = 2'd1;
        else if (wb_fwd_ok && (wb_rd == ex_rs1))
            fwd_a_sel = 2'd2;

        fwd_b_sel = 2'd0;
        if (!ex_imm) begin
            if (mem_fwd_ok && (mem_rd == ex_rs2))
                fwd_b_sel = 2'd1;
            else if (wb_fwd_ok && (wb_rd == ex_rs2))
                fwd_b_sel = 2'd2;
        end
    end

    // Load in EXE whose result is needed by the instruction in ID. The bubble
    // clears ex_mrd, so this drops after exactly one cycle.
    always_comb begin
        stall = ex_mrd && ex_wr && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (!id_use_imm && (ex_rd == id_rs2)));
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl
//   Directed scoreboard bench for forward_ctrl. Each stimulus step drives one
//   ID slot and queues the hand-computed outputs for that cycle; a monitor
//   on the falling edge pops and compares.
module tb_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_use_imm = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;
    logic [15:0] stall_count;

    forward_ctrl #(.AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_use_imm   (id_use_imm),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  a;
        logic [1:0]  b;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (fwd_b_sel == 2'd3) begin
            errors++;
            $display("FAIL b_sel_never_3: got %0d", fwd_b_sel);
        end
        checks++;
        if (dut.mem_mrd && fwd_a_sel == 2'd1) begin
            errors++;
            $display("FAIL no_load_fwd_from_exmem: a_sel=%0d with load in EX/MEM", fwd_a_sel);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (fwd_a_sel !== e.a) begin
                errors++;
                $display("FAIL %s fwd_a_sel: got %0d expected %0d", e.name, fwd_a_sel, e.a);
            end
            checks++;
            if (fwd_b_sel !== e.b) begin
                errors++;
                $display("FAIL %s fwd_b_sel: got %0d expected %0d", e.name, fwd_b_sel, e.b);
            end
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL %s stall: got %0b expected %0b", e.name, stall, e.st);
            end
            checks++;
            if (stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_use_imm = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One ID slot: drive inputs (and rst), queue expected outputs for this cycle.
    task automatic step(input string nm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wr, input logic mrd, input logic imm,
                        input logic fl, input logic r,
                        input logic [1:0] ea, input logic [1:0] eb,
                        input logic es, input logic [15:0] ec);
        exp_t e;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = wr; id_mem_read = mrd; id_use_imm = imm;
        flush = fl; rst = r;
        e.name = nm; e.a = ea; e.b = eb; e.st = es; e.cnt = ec;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        // 1) ADD r3<-r1,r2 ; SUB r4<-r3,r5
        do_reset();
        step("t1_reset",  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t1_add",    1, 2, 3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t1_sub",    3, 5, 4, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t1_sub_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1'b0, 16'd0);

        // 2) ADD r3 ; NOP ; OR r6<-r7,r3
        do_reset();
        step("t2_add",    1, 2, 3, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t2_nop",    0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t2_or",     7, 3, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t2_or_ex",  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 1'b0, 16'd0);

        // 3) LW r2<-(r1) ; ADD r8<-r2,r2 : one stall, bubble, then WB forwards
        do_reset();
        step("t3_lw",     1, 0, 2, 1, 1, 1, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t3_stall",  2, 2, 8, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b1, 16'd0);
        step("t3_bubble", 2, 2, 8, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd1);
        step("t3_add_ex", 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 1'b0, 16'd1);

        // 4) ADD r0 ; SUB r9<-r0,r0 ; LW r0 ; ADD r10<-r0,r0
        do_reset();
        step("t4_add_r0", 1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t4_sub",    0, 0, 9, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t4_lw_r0",  1, 0, 0, 1, 1, 1, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t4_use_r0", 0, 0, 10, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t4_tail",   0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);

        // 5) ADD r5 ; ADD r5 ; ADDI r6<-r5,imm (rs2 field also 5)
        do_reset();
        step("t5_add1",   1, 2, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t5_add2",   3, 4, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t5_addi",   5, 5, 6, 1, 0, 1, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t5_addi_ex",0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1'b0, 16'd0);

        // 6a) LW r4 ; consumer stalls ; rst during the stall cycle
        do_reset();
        step("t6_lw",     1, 0, 4, 1, 1, 1, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t6_stall_rst", 4, 1, 7, 1, 0, 0, 0, 1, 2'd0, 2'd0, 1'b1, 16'd0);
        step("t6_after_rst", 4, 1, 7, 1, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);

        // 6b) LW r4 ; consumer flushed while stalling
        do_reset();
        step("t6_lw2",    1, 0, 4, 1, 1, 1, 0, 0, 2'd0, 2'd0, 1'b0, 16'd0);
        step("t6_flush",  4, 1, 7, 1, 0, 0, 1, 0, 2'd0, 2'd0, 1'b1, 16'd0);
        step("t6_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd1);
        step("t6_tail",   0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 16'd1);

        // Drain: the monitor must have consumed every queued expectation.
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
